// File: rtl/dac_cfg_loader.sv
// dac_cfg_loader
//   Serial configuration controller for the DAC reference ladder. It receives
//   12-bit frames, MSB first, on sdi while sen is high. Each frame is
//   {addr[3:0], data[7:0]}. The frame writes a shadow register, commits all
//   shadows to the DAC-facing outputs, or clears the error flag.
//   Frame acceptance requires sen to be seen low in IDLE between frames
//   (armed), so a held-high sen cannot chain frames.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sdi          serial data, sampled on clk rise while sen=1
//   sen          frame enable, high for the whole frame
//   vref_o       active 4-bit reference code
//   vr_o/vm_o/vrc_o  active low/mid/high 3-bit range codes
//   upd_o        one-cycle pulse when the active outputs are updated by commit
//   busy_o       high in SHIFT, DECODE and SETTLE
//   err_o        sticky error flag (aborted frame or illegal address)
//   frame_cnt_o  count of accepted frames, wraps 255->0
module dac_cfg_loader #(
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  input  logic       sen,
  output logic [3:0] vref_o,
  output logic [2:0] vr_o,
  output logic [2:0] vm_o,
  output logic [2:0] vrc_o,
  output logic       upd_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [7:0] frame_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE, S_SETTLE} state_t;

  localparam bit         HAS_SETTLE  = (SETTLE_CYC > 0);
  // The DECODE cycle moves into SETTLE with this load. SETTLE then exits when
  // the counter reaches zero, so SETTLE lasts exactly SETTLE_CYC cycles.
  localparam logic [7:0] SETTLE_LOAD = HAS_SETTLE ? 8'(SETTLE_CYC - 1) : 8'd0;

  localparam logic [3:0] A_VREF   = 4'h0;
  localparam logic [3:0] A_VR     = 4'h1;
  localparam logic [3:0] A_VM     = 4'h2;
  localparam logic [3:0] A_VRC    = 4'h3;
  localparam logic [3:0] A_COMMIT = 4'h4;
  localparam logic [3:0] A_CLRERR = 4'hF;

  state_t      state, state_nxt;
  logic        armed;
  logic [3:0]  bit_cnt;
  logic [7:0]  settle_cnt;
  logic [11:0] shreg;

  logic [3:0]  sh_vref;
  logic [2:0]  sh_vr, sh_vm, sh_vrc;

  logic        shift_en;
  logic        abort;
  logic        decode;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        is_commit;
  logic        is_legal;

  assign addr      = shreg[11:8];
  assign data      = shreg[7:0];
  assign is_commit = (addr == A_COMMIT);
  assign is_legal  = (addr <= A_COMMIT) || (addr == A_CLRERR);
  assign busy_o    = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    abort     = 1'b0;
    decode    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sen && armed) begin
          shift_en  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!sen) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd11) state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        decode    = 1'b1;
        state_nxt = (is_commit && HAS_SETTLE) ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (settle_cnt == 8'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame assembly: the partial contents need no reset because they are only
  // consumed in DECODE, which is reachable only after 12 fresh samples.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {shreg[10:0], sdi};
  end

  // Control, shadows and DAC-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      armed       <= 1'b1;
      bit_cnt     <= 4'd0;
      settle_cnt  <= 8'd0;
      sh_vref     <= 4'd0;
      sh_vr       <= 3'd0;
      sh_vm       <= 3'd0;
      sh_vrc      <= 3'd0;
      vref_o      <= 4'd0;
      vr_o        <= 3'd0;
      vm_o        <= 3'd0;
      vrc_o       <= 3'd0;
      upd_o       <= 1'b0;
      err_o       <= 1'b0;
      frame_cnt_o <= 8'd0;
    end else begin
      state <= state_nxt;
      upd_o <= 1'b0;

      if (state == S_IDLE && !sen) armed <= 1'b1;

      if (shift_en) bit_cnt <= (state == S_IDLE) ? 4'd1 : bit_cnt + 4'd1;

      if (abort) begin
        err_o <= 1'b1;
        armed <= 1'b1;
      end

      if (state == S_SETTLE && settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;

      if (decode) begin
        armed      <= 1'b0;
        settle_cnt <= SETTLE_LOAD;
        if (is_legal) frame_cnt_o <= frame_cnt_o + 8'd1;
        else          err_o       <= 1'b1;
        case (addr)
          A_VREF:   sh_vref <= data[3:0];
          A_VR:     sh_vr   <= data[2:0];
          A_VM:     sh_vm   <= data[2:0];
          A_VRC:    sh_vrc  <= data[2:0];
          A_COMMIT: begin
            vref_o <= sh_vref;
            vr_o   <= sh_vr;
            vm_o   <= sh_vm;
            vrc_o  <= sh_vrc;
            upd_o  <= 1'b1;
          end
          A_CLRERR: err_o <= 1'b0;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_cfg_loader.sv
module tb_dac_cfg_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sdi;
  logic       sen;
  logic [3:0] vref_o;
  logic [2:0] vr_o, vm_o, vrc_o;
  logic       upd_o, busy_o, err_o;
  logic [7:0] frame_cnt_o;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  dac_cfg_loader #(.SETTLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sen(sen),
    .vref_o(vref_o), .vr_o(vr_o), .vm_o(vm_o), .vrc_o(vrc_o),
    .upd_o(upd_o), .busy_o(busy_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd_o) upd_cnt++;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] e_vref;
    logic [2:0] e_vr, e_vm, e_vrc;
    logic       e_err;
    logic [7:0] e_cnt;
    int         e_upd;
  } vec_t;

  vec_t vec [12];

  function automatic logic [21:0] outs();
    return {vref_o, vr_o, vm_o, vrc_o, err_o, frame_cnt_o};
  endfunction

  function automatic logic [21:0] expv(logic [3:0] a, logic [2:0] b, logic [2:0] c,
                                       logic [2:0] d, logic e, logic [7:0] n);
    return {a, b, c, d, e, n};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [11:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = f[11-i];
    end
  endtask

  // Drop sen, wait (bounded) for busy to fall, then one more cycle so the
  // loader sees sen low in IDLE and rearms.
  task automatic finish_frame();
    int n;
    @(negedge clk);
    sen = 1'b0;
    sdi = 1'b0;
    n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [7:0] d);
    shift_bits({a, d}, 12);
    finish_frame();
  endtask

  initial begin
    int u0;
    logic [23:0] two;

    rst_n = 1'b0;
    sen   = 1'b0;
    sdi   = 1'b0;

    //            addr  data   vref  vr    vm    vrc   err  cnt   upd
    vec[0]  = '{4'h1, 8'h05, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd1,  0};
    vec[1]  = '{4'h2, 8'h03, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd2,  0};
    vec[2]  = '{4'h3, 8'h07, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd3,  0};
    vec[3]  = '{4'h0, 8'h0A, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'd4,  0};
    vec[4]  = '{4'h4, 8'h00, 4'hA, 3'd5, 3'd3, 3'd7, 1'b0, 8'd5,  1};
    vec[5]  = '{4'h7, 8'h00, 4'hA, 3'd5, 3'd3, 3'd7, 1'b1, 8'd5,  0};
    vec[6]  = '{4'hF, 8'h00, 4'hA, 3'd5, 3'd3, 3'd7, 1'b0, 8'd6,  0};
    vec[7]  = '{4'h0, 8'hF3, 4'hA, 3'd5, 3'd3, 3'd7, 1'b0, 8'd7,  0};
    vec[8]  = '{4'h1, 8'hFE, 4'hA, 3'd5, 3'd3, 3'd7, 1'b0, 8'd8,  0};
    vec[9]  = '{4'h4, 8'hFF, 4'h3, 3'd6, 3'd3, 3'd7, 1'b0, 8'd9,  1};
    vec[10] = '{4'h9, 8'h00, 4'h3, 3'd6, 3'd3, 3'd7, 1'b1, 8'd9,  0};
    vec[11] = '{4'hF, 8'h00, 4'h3, 3'd6, 3'd3, 3'd7, 1'b0, 8'd10, 0};

    repeat (3) @(negedge clk);
    check("reset_state", {10'd0, outs(), busy_o, upd_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      u0 = upd_cnt;
      send_frame(vec[i].addr, vec[i].data);
      check($sformatf("vec%0d_outs", i), {10'd0, outs()},
            {10'd0, expv(vec[i].e_vref, vec[i].e_vr, vec[i].e_vm, vec[i].e_vrc,
                         vec[i].e_err, vec[i].e_cnt)});
      check($sformatf("vec%0d_upd", i), upd_cnt - u0, vec[i].e_upd);
    end

    // Commit timing, settle length and sen ignored during SETTLE
    send_frame(4'h2, 8'h01);
    u0 = upd_cnt;
    shift_bits({4'h4, 8'h00}, 12);
    @(negedge clk);                      // state DECODE
    check("commit_pre_outs", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd3, 3'd7, 1'b0, 8'd11)});
    check("commit_pre_upd", {upd_o, busy_o}, 2'b01);
    sen = 1'b0;
    @(negedge clk);                      // after k+12
    check("commit_outs", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd1, 3'd7, 1'b0, 8'd12)});
    check("commit_upd", {upd_o, busy_o}, 2'b11);
    sen = 1'b1;
    sdi = 1'b1;
    @(negedge clk);                      // after k+13
    check("settle1", {upd_o, busy_o}, 2'b01);
    sen = 1'b0;
    sdi = 1'b0;
    @(negedge clk);
    check("settle2_busy", busy_o, 1'b1);
    @(negedge clk);
    check("settle3_busy", busy_o, 1'b1);
    @(negedge clk);                      // after k+16
    check("settle_end_busy", busy_o, 1'b0);
    @(negedge clk);
    check("settle_sen_ignored", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd1, 3'd7, 1'b0, 8'd12)});
    check("settle_upd_once", upd_cnt - u0, 1);

    // Abort after 7 bits
    shift_bits({4'h0, 8'h05}, 7);
    @(negedge clk);
    sen = 1'b0;
    @(negedge clk);
    check("abort_outs", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd1, 3'd7, 1'b1, 8'd12)});
    check("abort_busy", busy_o, 1'b0);
    @(negedge clk);
    send_frame(4'hF, 8'h00);
    check("abort_clr", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd1, 3'd7, 1'b0, 8'd13)});
    send_frame(4'h4, 8'h00);
    check("abort_no_write", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd1, 3'd7, 1'b0, 8'd14)});

    // sen held high for two frames' worth of bits: only the first is taken
    u0  = upd_cnt;
    two = {4'h1, 8'h02, 4'h4, 8'h00};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = two[23-i];
    end
    finish_frame();
    check("held_sen", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd6, 3'd1, 3'd7, 1'b0, 8'd15)});
    check("held_sen_no_commit", upd_cnt - u0, 0);
    send_frame(4'h4, 8'h00);
    check("rearm_commit", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd2, 3'd1, 3'd7, 1'b0, 8'd16)});

    // Frame counter wrap
    for (int i = 0; i < 240; i++) send_frame(4'hF, 8'h00);
    check("cnt_wrap", {10'd0, outs()}, {10'd0, expv(4'h3, 3'd2, 3'd1, 3'd7, 1'b0, 8'd0)});

    // Reset in the middle of a frame
    shift_bits({4'h3, 8'h04}, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_reset", {10'd0, outs(), busy_o, upd_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sen   = 1'b0;
    sdi   = 1'b0;
    @(negedge clk);
    send_frame(4'h3, 8'h04);
    send_frame(4'h4, 8'h00);
    check("post_reset_frame", {10'd0, outs()}, {10'd0, expv(4'h0, 3'd0, 3'd0, 3'd4, 1'b0, 8'd2)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_cfg_loader.md
# dac_cfg_loader

Serial configuration controller for the DAC reference ladder. It shifts 12-bit frames in from a one-wire data/enable pair and writes them into shadow registers for the 4-bit reference code and the low/mid/high 3-bit range codes. On a commit command it transfers all shadows to the DAC-facing outputs in the same cycle. It sits between the chip input pins and the DAC reference/range latches, and replaces per-bit enable strobing with a framed, error-checked protocol.

## Interface

Parameters:
- SETTLE_CYC, default 4: busy cycles held after a commit so the DAC can settle; legal range 0..255; 0 skips SETTLE.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- sdi  in  1  serial data, MSB first, sampled on clk rise while sen=1
- sen  in  1  frame enable, high for the whole frame
- vref_o  out  4  active reference code
- vr_o  out  3  active low-range code
- vm_o  out  3  active mid-range code
- vrc_o  out  3  active high-range code
- upd_o  out  1  one-cycle pulse when active outputs change (commit)
- busy_o  out  1  high in SHIFT, DECODE, SETTLE
- err_o  out  1  sticky error flag
- frame_cnt_o  out  8  count of accepted frames, wraps 255->0

## Operation

- Frame format: 12 bits, MSB first. Bits [11:8] are addr; bits [7:0] are data.
- Address map:
  - 0: shadow vref <= data[3:0]
  - 1: shadow vr <= data[2:0]
  - 2: shadow vm <= data[2:0]
  - 3: shadow vrc <= data[2:0]
  - 4: commit. Data is ignored. All four shadows are copied to the outputs simultaneously and upd_o pulses.
  - 0xF: clear err_o.
  - Any other addr: set err_o. No register changes and frame_cnt_o is not incremented.
- Unused data bits are ignored.
- Accepted frames (addr 0-4, 0xF) increment frame_cnt_o by 1.
- States and transitions:
  - IDLE: if sen=1 and armed, sample bit 1 and go to SHIFT with bit count=1. If sen=0, set armed=1.
  - SHIFT: if sen=1, sample the next bit; when the 12th bit is sampled, go to DECODE. If sen=0 before 12 bits, abort: set err_o, discard the partial frame, go to IDLE with armed=1.
  - DECODE: one cycle; perform the write/commit/clear. Go to SETTLE if commit and SETTLE_CYC>0, otherwise go to IDLE. Clear armed.
  - SETTLE: count down SETTLE_CYC cycles, then go to IDLE.
- Rearm rule: after a complete frame, sen must be seen low in IDLE before a new frame is accepted. This prevents a held-high sen from chaining frames.
- sdi/sen are ignored in DECODE and SETTLE. A sen level there does not corrupt state, and the rearm rule still applies.
- A write to a shadow register never changes the outputs until a commit.
- Reset values:
  - All outputs are 0: vref_o, vr_o, vm_o, vrc_o, upd_o, busy_o, err_o, frame_cnt_o.
  - Shadows are 0, state is IDLE, armed=1.
- Reset mid-frame or mid-settle: reset clears everything immediately. No partial write occurs.

## Timing

- First bit is sampled at edge k, where sen=1 in IDLE. The 12th bit is sampled at edge k+11 and the state becomes DECODE.
- At edge k+12:
  - shadow/err/frame_cnt update;
  - on commit, outputs update and upd_o is high for the cycle k+12..k+13;
  - state becomes SETTLE or IDLE.
- busy_o rises after edge k. On commit it falls after edge k+12+SETTLE_CYC; otherwise it falls after edge k+12.
- Earliest next frame: the first bit can be sampled one edge after sen is seen low in IDLE.
- An abort (sen low in SHIFT) sets err_o at that edge, and the state is IDLE on the next cycle.

## Test plan

- Send frames addr1 data 0x05, addr2 data 0x03, addr3 data 0x07, addr0 data 0x0A, then addr4 -> outputs stay 0 until the commit frame. Then vr_o=5, vm_o=3, vrc_o=7, vref_o=0xA all change at the same edge, upd_o pulses once, and frame_cnt_o=5.
- Commit with SETTLE_CYC=4 -> busy_o stays high for 4 cycles after DECODE. A sen pulse sent during SETTLE is ignored and frame_cnt_o is unchanged.
- Drop sen after 7 bits -> err_o=1, no register changes, frame_cnt_o is unchanged. A following addr 0xF frame -> err_o=0 and frame_cnt_o increments.
- Hold sen high for 24 cycles with valid bits -> only the first frame is accepted. A second frame is accepted only after sen goes low for at least one cycle.
- Send an addr 7 frame -> err_o=1 and frame_cnt_o is unchanged. Send 256 accepted frames -> frame_cnt_o wraps to 0.
- Assert rst_n=0 at bit 6 of a frame -> all outputs are 0 immediately. After release, a fresh full frame is decoded correctly.
